regfile_ctx_ctrl: RTL and testbench

Sits between the CPU pipeline and the block-RAM register file and owns all four register file ports. In normal operation it passes the pipeline's ports straight through. On an interrupt save or restore request it stalls the pipeline and sequences a copy between the live registers R0–R13 and the shadow bank in scratch entries R16–R29. R31 is the dummy write sink, because the register file writes every cycle and has no write enable.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_ctx_ctrl_bypass.sv | 60 ++++++
 rtl/regfile_ctx_ctrl.sv | 157 +++++++++++++++
 tb/tb_regfile_ctx_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file context controller.
// Optional bypass feature selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int REG_BITS    = 5;
    localparam int BITS        = 16;
    localparam int SAVE_COUNT  = 14;
    localparam int SHADOW_BASE = 16;
    localparam int NULL_REG    = 31;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic {
        SAVE,
        RESTORE
    } dir_e;

endpackage

// File: rtl/regfile_ctx_ctrl_bypass.sv
// Write-to-read forwarding for the pipeline read ports.
// Instantiated only when REGFILE_BYPASS_EN is defined.
module regfile_bypass #(
    parameter int REG_BITS = regfile_pkg::REG_BITS,
    parameter int BITS     = regfile_pkg::BITS,
    parameter int NULL_REG = regfile_pkg::NULL_REG
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                stall,
    input  logic [REG_BITS-1:0] wr_addr,
    input  logic [BITS-1:0]     wr_data,
    input  logic [REG_BITS-1:0] rd_addr_a,
    input  logic [REG_BITS-1:0] rd_addr_b,
    input  logic [BITS-1:0]     rf_data_a,
    input  logic [BITS-1:0]     rf_data_b,
    output logic [BITS-1:0]     data_a,
    output logic [BITS-1:0]     data_b
);

    localparam logic [REG_BITS-1:0] NULL_A = REG_BITS'(NULL_REG);

    logic [REG_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [BITS-1:0]     wr_data_q, wr_data_d;
    logic [REG_BITS-1:0] rd_a_q, rd_a_d;
    logic [REG_BITS-1:0] rd_b_q, rd_b_d;
    logic                hit_a, hit_b;

    // Capture last cycle's pipeline write and read addresses; ignore writes while held
    always_comb begin
        wr_addr_d = stall ? NULL_A : wr_addr;
        wr_data_d = wr_data;
        rd_a_d    = rd_addr_a;
        rd_b_d    = rd_addr_b;
    end

    // Forwarding state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_addr_q <= NULL_A;
            wr_data_q <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
        end
    end

    // Substitute the fresh write data when the RAM would return the stale value
    always_comb begin
        hit_a  = !stall && (wr_addr_q != NULL_A) && (rd_a_q == wr_addr_q);
        hit_b  = !stall && (wr_addr_q != NULL_A) && (rd_b_q == wr_addr_q);
        data_a = hit_a ? wr_data_q : rf_data_a;
        data_b = hit_b ? wr_data_q : rf_data_b;
    end

endmodule

// File: rtl/regfile_ctx_ctrl.sv
// Owns the register-file ports; sequences live<->shadow copies on interrupt.
// Define REGFILE_BYPASS_EN to add write-to-read forwarding on cpu reads.
module regfile_ctx_ctrl
    import regfile_pkg::*;
#(
    parameter int REG_BITS    = regfile_pkg::REG_BITS,
    parameter int BITS        = regfile_pkg::BITS,
    parameter int SAVE_COUNT  = regfile_pkg::SAVE_COUNT,
    parameter int SHADOW_BASE = regfile_pkg::SHADOW_BASE,
    parameter int NULL_REG    = regfile_pkg::NULL_REG
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [REG_BITS-1:0] cpu_regIn,
    input  logic [BITS-1:0]     cpu_regIn_data,
    input  logic [REG_BITS-1:0] cpu_regOutA,
    input  logic [REG_BITS-1:0] cpu_regOutB,
    output logic [BITS-1:0]     cpu_regOutA_data,
    output logic [BITS-1:0]     cpu_regOutB_data,
    output logic [REG_BITS-1:0] rf_regIn,
    output logic [BITS-1:0]     rf_regIn_data,
    output logic [REG_BITS-1:0] rf_regOutA,
    output logic [REG_BITS-1:0] rf_regOutB,
    input  logic [BITS-1:0]     rf_regOutA_data,
    input  logic [BITS-1:0]     rf_regOutB_data,
    input  logic                save_req,
    input  logic                restore_req,
    output logic                stall,
    output logic                ack
);

    if (SHADOW_BASE + SAVE_COUNT > NULL_REG) begin : g_bad_cfg
        $error("shadow bank overlaps the null register");
    end

    localparam logic [REG_BITS-1:0] NULL_A   = REG_BITS'(NULL_REG);
    localparam logic [REG_BITS-1:0] SHADOW_A = REG_BITS'(SHADOW_BASE);
    localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(SAVE_COUNT - 1);

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [REG_BITS-1:0] rd_idx_q, rd_idx_d;
    logic [REG_BITS-1:0] wr_addr_q, wr_addr_d;
    logic                stall_q, stall_d;
    logic                ack_q, ack_d;
    logic [REG_BITS-1:0] src_addr, dst_addr;

    // Source and destination of the element currently being read
    always_comb begin
        src_addr = (dir_q == SAVE) ? rd_idx_q : SHADOW_A + rd_idx_q;
        dst_addr = (dir_q == SAVE) ? SHADOW_A + rd_idx_q : rd_idx_q;
    end

    // Sequencer next state; writes lag reads by one cycle via wr_addr
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rd_idx_d  = rd_idx_q;
        wr_addr_d = wr_addr_q;
        stall_d   = stall_q;
        ack_d     = ack_q;
        unique case (state_q)
            IDLE: begin
                if (save_req || restore_req) begin
                    state_d   = COPY;
                    dir_d     = save_req ? SAVE : RESTORE;
                    rd_idx_d  = '0;
                    wr_addr_d = NULL_A;
                    stall_d   = 1'b1;
                end
            end
            COPY: begin
                wr_addr_d = dst_addr;
                if (rd_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d   = DONE;
                wr_addr_d = NULL_A;
                ack_d     = 1'b1;
            end
            DONE: begin
                state_d  = IDLE;
                rd_idx_d = '0;
                stall_d  = 1'b0;
                ack_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and registered handshake outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            dir_q     <= SAVE;
            rd_idx_q  <= '0;
            wr_addr_q <= NULL_A;
            stall_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rd_idx_q  <= rd_idx_d;
            wr_addr_q <= wr_addr_d;
            stall_q   <= stall_d;
            ack_q     <= ack_d;
        end
    end

    // Port ownership: pipeline in IDLE, sequencer otherwise
    always_comb begin
        rf_regIn      = cpu_regIn;
        rf_regIn_data = cpu_regIn_data;
        rf_regOutA    = cpu_regOutA;
        rf_regOutB    = cpu_regOutB;
        if (state_q != IDLE) begin
            rf_regIn      = wr_addr_q;
            rf_regIn_data = rf_regOutA_data;
            rf_regOutA    = (state_q == COPY) ? src_addr : '0;
            rf_regOutB    = '0;
        end
        if (RST) begin
            rf_regIn = NULL_A;
        end
    end

    assign stall = stall_q;
    assign ack   = ack_q;

`ifdef REGFILE_BYPASS_EN
    regfile_bypass #(
        .REG_BITS (REG_BITS),
        .BITS     (BITS),
        .NULL_REG (NULL_REG)
    ) u_bypass (
        .CLK       (CLK),
        .RST       (RST),
        .stall     (stall_q),
        .wr_addr   (cpu_regIn),
        .wr_data   (cpu_regIn_data),
        .rd_addr_a (cpu_regOutA),
        .rd_addr_b (cpu_regOutB),
        .rf_data_a (rf_regOutA_data),
        .rf_data_b (rf_regOutB_data),
        .data_a    (cpu_regOutA_data),
        .data_b    (cpu_regOutB_data)
    );
`else
    assign cpu_regOutA_data = rf_regOutA_data;
    assign cpu_regOutB_data = rf_regOutB_data;
`endif

endmodule

// File: tb/tb_regfile_ctx_ctrl.sv
// Directed bench for regfile_ctx_ctrl with a read-before-write RAM model.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_ctx_ctrl;

    logic        CLK;
    logic        RST;
    logic [4:0]  cpu_regIn;
    logic [15:0] cpu_regIn_data;
    logic [4:0]  cpu_regOutA;
    logic [4:0]  cpu_regOutB;
    logic [15:0] cpu_regOutA_data;
    logic [15:0] cpu_regOutB_data;
    logic [4:0]  rf_regIn;
    logic [15:0] rf_regIn_data;
    logic [4:0]  rf_regOutA;
    logic [4:0]  rf_regOutB;
    logic [15:0] rf_regOutA_data;
    logic [15:0] rf_regOutB_data;
    logic        save_req;
    logic        restore_req;
    logic        stall;
    logic        ack;

    logic [15:0] mem [32];
    int          n_chk;
    int          n_err;

    regfile_ctx_ctrl dut (
        .CLK              (CLK),
        .RST              (RST),
        .cpu_regIn        (cpu_regIn),
        .cpu_regIn_data   (cpu_regIn_data),
        .cpu_regOutA      (cpu_regOutA),
        .cpu_regOutB      (cpu_regOutB),
        .cpu_regOutA_data (cpu_regOutA_data),
        .cpu_regOutB_data (cpu_regOutB_data),
        .rf_regIn         (rf_regIn),
        .rf_regIn_data    (rf_regIn_data),
        .rf_regOutA       (rf_regOutA),
        .rf_regOutB       (rf_regOutB),
        .rf_regOutA_data  (rf_regOutA_data),
        .rf_regOutB_data  (rf_regOutB_data),
        .save_req         (save_req),
        .restore_req      (restore_req),
        .stall            (stall),
        .ack              (ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Block RAM: registered read, no write enable, old data on collision
    always @(posedge CLK) begin
        rf_regOutA_data <= mem[rf_regOutA];
        rf_regOutB_data <= mem[rf_regOutB];
        mem[rf_regIn]   <= rf_regIn_data;
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        cpu_regIn      = a;
        cpu_regIn_data = d;
        tick();
        cpu_regIn      = 5'd31;
        cpu_regIn_data = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [15:0] v);
        cpu_regOutA = a;
        tick();
        v = cpu_regOutA_data;
    endtask

    task automatic run_req(input logic s, input logic r,
                           output int stall_n, output int ack_n);
        save_req    = s;
        restore_req = r;
        stall_n     = 0;
        ack_n       = 0;
        repeat (24) begin
            tick();
            if (stall) stall_n++;
            if (ack) begin
                ack_n++;
                save_req    = 1'b0;
                restore_req = 1'b0;
            end
        end
        save_req    = 1'b0;
        restore_req = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        int          sn;
        int          an;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hC000 + 16'(i);
        RST            = 1'b1;
        cpu_regIn      = 5'd5;
        cpu_regIn_data = 16'h7777;
        cpu_regOutA    = '0;
        cpu_regOutB    = '0;
        save_req       = 1'b0;
        restore_req    = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_regIn", 16'(rf_regIn), 16'd31);
            check("rst_stall", 16'(stall), 16'd0);
            check("rst_ack", 16'(ack), 16'd0);
        end
        RST            = 1'b0;
        cpu_regIn      = 5'd7;
        cpu_regIn_data = 16'h1234;
        cpu_regOutA    = 5'd9;
        #1;
        check("pass_regIn", 16'(rf_regIn), 16'd7);
        check("pass_data", rf_regIn_data, 16'h1234);
        check("pass_outA", 16'(rf_regOutA), 16'd9);
        tick();
        cpu_regIn = 5'd31;
        check("pass_rdA", cpu_regOutA_data, 16'hC009);

        for (int i = 0; i < 14; i++) wr(5'(i), 16'h1000 + 16'(i));
        run_req(1'b1, 1'b0, sn, an);
        check("save_stall", 16'(sn), 16'd16);
        check("save_ack", 16'(an), 16'd1);
        for (int i = 0; i < 14; i++) begin
            rd(5'(16 + i), v);
            check($sformatf("save_r%0d", 16 + i), v, 16'h1000 + 16'(i));
        end
        rd(5'd14, v);
        check("save_r14", v, 16'hC00E);
        rd(5'd15, v);
        check("save_r15", v, 16'hC00F);
        rd(5'd30, v);
        check("save_r30", v, 16'hC01E);

        for (int i = 0; i < 14; i++) wr(5'(i), 16'h0000);
        run_req(1'b0, 1'b1, sn, an);
        check("rest_stall", 16'(sn), 16'd16);
        check("rest_ack", 16'(an), 16'd1);
        for (int i = 0; i < 14; i++) begin
            rd(5'(i), v);
            check($sformatf("rest_r%0d", i), v, 16'h1000 + 16'(i));
        end
        rd(5'd14, v);
        check("rest_r14", v, 16'hC00E);
        rd(5'd15, v);
        check("rest_r15", v, 16'hC00F);

        wr(5'd0, 16'hAAAA);
        run_req(1'b1, 1'b1, sn, an);
        check("both_ack", 16'(an), 16'd1);
        rd(5'd16, v);
        check("both_r16", v, 16'hAAAA);
        rd(5'd0, v);
        check("both_r0", v, 16'hAAAA);

        save_req = 1'b1;
        repeat (5) tick();
        check("abort_busy", 16'(stall), 16'd1);
        RST      = 1'b1;
        save_req = 1'b0;
        tick();
        check("abort_stall", 16'(stall), 16'd0);
        check("abort_ack", 16'(ack), 16'd0);
        RST = 1'b0;
        an  = 0;
        repeat (20) begin
            tick();
            if (ack) an++;
        end
        check("abort_noack", 16'(an), 16'd0);
        wr(5'd1, 16'h5555);
        run_req(1'b1, 1'b0, sn, an);
        check("resave_stall", 16'(sn), 16'd16);
        check("resave_ack", 16'(an), 16'd1);
        rd(5'd17, v);
        check("resave_r17", v, 16'h5555);

        cpu_regIn      = 5'd3;
        cpu_regIn_data = 16'hBEEF;
        cpu_regOutA    = 5'd3;
        tick();
        cpu_regIn      = 5'd31;
        cpu_regIn_data = '0;
`ifdef REGFILE_BYPASS_EN
        check("byp_raw", cpu_regOutA_data, 16'hBEEF);
`else
        check("byp_raw", cpu_regOutA_data, 16'h1003);
`endif
        rd(5'd3, v);
        check("byp_after", v, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
